wbu_writeback: RTL and testbench
================================

Name: wbu_writeback

Overview:
- Write-back unit of the NPC core; sits directly upstream of the integer register file and drives its write port (we, rd_addr, rd_data).
- Accepts one retiring instruction per handshake from the execute/LSU side.
- For loads, waits for the memory read response, then aligns and sign/zero-extends it.
- Issues exactly one register-file write pulse plus a commit pulse per instruction, and exposes the in-flight destination register for hazard detection.

Parameters:
- WIDTH, 32, data path and PC width in bits (only 32 is supported).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream has a retiring instruction
- in_ready  output  1  unit can accept an instruction this cycle
- in_pc  input  WIDTH  PC of the instruction
- in_rd  input  5  destination register index
- in_rd_wen  input  1  instruction writes rd
- in_is_load  input  1  result comes from memory
- in_load_fmt  input  3  load funct3 (LB/LH/LW/LBU/LHU)
- in_addr_lo  input  2  low bits of the load address
- in_result  input  WIDTH  ALU/CSR result (used when in_is_load=0)
- mem_rvalid  input  1  memory read data valid
- mem_rdata  input  WIDTH  memory read word, naturally aligned
- rf_we  output  1  register-file write enable
- rf_rd_addr  output  5  register-file write index
- rf_rd_data  output  WIDTH  register-file write data
- commit_valid  output  1  one-cycle retire pulse
- commit_pc  output  WIDTH  PC of the retiring instruction
- pend_valid  output  1  an instruction is in flight and has rd_wen=1
- pend_rd  output  5  rd of the in-flight instruction

Behaviour:
- Reset: asynchronous, active-high. Forces state IDLE and clears all registered outputs to 0: rf_we, rf_rd_addr, rf_rd_data, commit_valid, commit_pc, pend_valid, pend_rd. While in IDLE, in_ready=1.
- States: IDLE, WAIT_MEM, WRITE. in_ready = (state==IDLE); it is purely a function of state.
- IDLE:
  - On in_valid & in_ready, latch pc, rd, rd_wen, load_fmt and addr_lo.
  - If is_load=1, go to WAIT_MEM.
  - Otherwise, latch in_result as data and go to WRITE.
  - in_valid=0: remain in IDLE.
- WAIT_MEM:
  - in_ready=0.
  - On mem_rvalid=1, latch the aligned and extended mem_rdata, then go to WRITE.
  - mem_rvalid=0: wait indefinitely; there is no timeout.
  - mem_rvalid is ignored in IDLE and WRITE.
- WRITE (exactly one cycle, then return to IDLE):
  - rf_we = rd_wen & (rd!=0); no write is issued for x0.
  - rf_rd_addr = rd; rf_rd_data = data.
  - commit_valid=1; commit_pc = pc.
  - commit_valid is asserted even when rd_wen=0 or rd=0.
- Output timing: all outputs are registered and are 0 outside WRITE.
  - rf_rd_addr and rf_rd_data hold their last values, but are only meaningful while rf_we=1.
- Latency:
  - Non-load accepted at edge T: rf_we/commit_valid high in cycle T+1.
  - Load: mem_rvalid sampled at edge M: write in cycle M+1.
  - Peak throughput: one non-load instruction every 2 cycles.
- Pending-register tracking:
  - pend_valid = 1 from the cycle after acceptance through the WRITE cycle inclusive, when rd_wen=1 and rd!=0.
  - pend_rd = latched rd.
- Load alignment, with sh = addr_lo*8:
  - 000 LB: sign-extend mem_rdata[sh+7:sh].
  - 100 LBU: zero-extend mem_rdata[sh+7:sh].
  - 001 LH: sign-extend halfword selected by addr_lo[1]; addr_lo[0] is ignored.
  - 101 LHU: zero-extend halfword selected by addr_lo[1]; addr_lo[0] is ignored.
  - 010 LW, and any other code: full word; addr_lo is ignored.
  - Misalignment is not detected here.
- Reset mid-operation (in WAIT_MEM or WRITE): the instruction is dropped, with no rf_we and no commit. A later mem_rvalid is ignored.

Decomposition:
- Shared package (npc_pkg):
  - funct3 load constants LB/LH/LW/LBU/LHU.
  - WBU state encoding IDLE/WAIT_MEM/WRITE.
  - Register index width constant (5).
- One sub-module: wbu_load_align, purely combinational. Takes mem_rdata, load_fmt and addr_lo; produces the extended word.

Test Plan:
- ALU write: accept pc=0x80000000, rd=5, wen=1, result=0x12345678. Next cycle: rf_we=1, rf_rd_addr=5, rf_rd_data=0x12345678, commit_valid=1, commit_pc=0x80000000; in_ready returns to 1 the following cycle.
- x0 and no-write: rd=0, wen=1 → rf_we=0, commit_valid=1. rd=3, wen=0 → rf_we=0, commit_valid=1, pend_valid=0 throughout.
- Load extension with mem_rdata=0x80FF7F01:
  - LB, addr_lo=2 → 0xFFFFFFFF.
  - LBU, addr_lo=3 → 0x00000080.
  - LH, addr_lo=2 → 0xFFFF80FF.
  - LHU, addr_lo=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- Memory wait: load accepted, mem_rvalid held 0 for 5 cycles. Required: in_ready=0, pend_valid=1, pend_rd=rd, rf_we=0 throughout. mem_rvalid=1 then gives rf_we one cycle later. A mem_rvalid pulse while IDLE causes no write.
- Back-to-back: in_valid held 1 with 3 non-load instructions. Required: acceptances in cycles 0, 2, 4 and commits in cycles 1, 3, 5, in order, with matching pc/rd.
- Reset mid-load: assert rst in WAIT_MEM, then release and pulse mem_rvalid. Required: all outputs 0 immediately on rst, no rf_we or commit_valid ever, and in_ready=1 after release.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core: load funct3 encodings, register index
// width and the write-back unit state encoding.
package npc_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wbu_state_e;

endpackage

// File: rtl/wbu_load_align.sv
// Selects the addressed byte/halfword of a naturally aligned memory word and
// sign- or zero-extends it according to the load funct3.
module wbu_load_align
    import npc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [2:0]       load_fmt,
    input  logic [1:0]       addr_lo,
    output logic [WIDTH-1:0] load_data
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = mem_rdata[7:0];
        unique case (addr_lo)
            2'd0:    byteSel = mem_rdata[7:0];
            2'd1:    byteSel = mem_rdata[15:8];
            2'd2:    byteSel = mem_rdata[23:16];
            2'd3:    byteSel = mem_rdata[31:24];
            default: byteSel = mem_rdata[7:0];
        endcase
    end

    // Halfword loads only look at addr_lo[1]; a misaligned addr_lo[0] is ignored.
    assign halfSel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = mem_rdata;
        case (load_fmt)
            F3_LB:   load_data = {{(WIDTH-8){byteSel[7]}}, byteSel};
            F3_LBU:  load_data = {{(WIDTH-8){1'b0}}, byteSel};
            F3_LH:   load_data = {{(WIDTH-16){halfSel[15]}}, halfSel};
            F3_LHU:  load_data = {{(WIDTH-16){1'b0}}, halfSel};
            F3_LW:   load_data = mem_rdata;
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/wbu_writeback.sv
// Write-back unit: retires one instruction per handshake, waits for load data
// when needed and issues a single register-file write plus a commit pulse.
module wbu_writeback
    import npc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_pc,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_rd_wen,
    input  logic                 in_is_load,
    input  logic [2:0]           in_load_fmt,
    input  logic [1:0]           in_addr_lo,
    input  logic [WIDTH-1:0]     in_result,
    input  logic                 mem_rvalid,
    input  logic [WIDTH-1:0]     mem_rdata,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_rd_addr,
    output logic [WIDTH-1:0]     rf_rd_data,
    output logic                 commit_valid,
    output logic [WIDTH-1:0]     commit_pc,
    output logic                 pend_valid,
    output logic [REG_IDX_W-1:0] pend_rd
);

    wbu_state_e state_q, state_d;

    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;
    logic                 wen_q, wen_d;
    logic [2:0]           fmt_q, fmt_d;
    logic [1:0]           addrLo_q, addrLo_d;

    logic                 rfWe_q, rfWe_d;
    logic [REG_IDX_W-1:0] rfRdAddr_q, rfRdAddr_d;
    logic [WIDTH-1:0]     rfRdData_q, rfRdData_d;
    logic                 commitValid_q, commitValid_d;
    logic [WIDTH-1:0]     commitPc_q, commitPc_d;
    logic                 pendValid_q, pendValid_d;
    logic [REG_IDX_W-1:0] pendRd_q, pendRd_d;

    logic [WIDTH-1:0]     loadData;
    logic                 accept;
    logic                 inWrites;
    logic                 heldWrites;

    wbu_load_align #(
        .WIDTH (WIDTH)
    ) u_align (
        .mem_rdata (mem_rdata),
        .load_fmt  (fmt_q),
        .addr_lo   (addrLo_q),
        .load_data (loadData)
    );

    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid & in_ready;
    assign inWrites   = in_rd_wen && (in_rd != '0);
    assign heldWrites = wen_q && (rd_q != '0);

    // Write-phase outputs are computed one cycle early so that they leave the
    // unit straight from flops during the WRITE cycle.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rd_d          = rd_q;
        wen_d         = wen_q;
        fmt_d         = fmt_q;
        addrLo_d      = addrLo_q;
        rfWe_d        = 1'b0;
        rfRdAddr_d    = rfRdAddr_q;
        rfRdData_d    = rfRdData_q;
        commitValid_d = 1'b0;
        commitPc_d    = '0;
        pendValid_d   = pendValid_q;
        pendRd_d      = pendRd_q;

        unique case (state_q)
            IDLE: begin
                pendValid_d = 1'b0;
                if (accept) begin
                    pc_d        = in_pc;
                    rd_d        = in_rd;
                    wen_d       = in_rd_wen;
                    fmt_d       = in_load_fmt;
                    addrLo_d    = in_addr_lo;
                    pendValid_d = inWrites;
                    pendRd_d    = in_rd;
                    if (in_is_load) begin
                        state_d = WAIT_MEM;
                    end else begin
                        state_d       = WRITE;
                        rfWe_d        = inWrites;
                        rfRdAddr_d    = in_rd;
                        rfRdData_d    = in_result;
                        commitValid_d = 1'b1;
                        commitPc_d    = in_pc;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d       = WRITE;
                    rfWe_d        = heldWrites;
                    rfRdAddr_d    = rd_q;
                    rfRdData_d    = loadData;
                    commitValid_d = 1'b1;
                    commitPc_d    = pc_q;
                end
            end
            WRITE: begin
                state_d     = IDLE;
                pendValid_d = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                pendValid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            rd_q          <= '0;
            wen_q         <= 1'b0;
            fmt_q         <= '0;
            addrLo_q      <= '0;
            rfWe_q        <= 1'b0;
            rfRdAddr_q    <= '0;
            rfRdData_q    <= '0;
            commitValid_q <= 1'b0;
            commitPc_q    <= '0;
            pendValid_q   <= 1'b0;
            pendRd_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rd_q          <= rd_d;
            wen_q         <= wen_d;
            fmt_q         <= fmt_d;
            addrLo_q      <= addrLo_d;
            rfWe_q        <= rfWe_d;
            rfRdAddr_q    <= rfRdAddr_d;
            rfRdData_q    <= rfRdData_d;
            commitValid_q <= commitValid_d;
            commitPc_q    <= commitPc_d;
            pendValid_q   <= pendValid_d;
            pendRd_q      <= pendRd_d;
        end
    end

    assign rf_we        = rfWe_q;
    assign rf_rd_addr   = rfRdAddr_q;
    assign rf_rd_data   = rfRdData_q;
    assign commit_valid = commitValid_q;
    assign commit_pc    = commitPc_q;
    assign pend_valid   = pendValid_q;
    assign pend_rd      = pendRd_q;

endmodule

// File: tb/tb_wbu_writeback.sv
// Self-checking bench for wbu_writeback: table-driven instruction vectors with
// a commit scoreboard, plus hand-written multi-cycle sequences.
module tb_wbu_writeback;
    import npc_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        in_is_load;
    logic [2:0]  in_load_fmt;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        pend_valid;
    logic [4:0]  pend_rd;

    typedef struct {
        logic        isLoad;
        logic [4:0]  rd;
        logic        wen;
        logic [2:0]  fmt;
        logic [1:0]  addrLo;
        logic [31:0] result;
        logic [31:0] mdata;
        logic        expWe;
        logic [31:0] expData;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } sbEntry_t;

    sbEntry_t sb[$];
    sbEntry_t monEntry;
    vec_t     vecs[14];
    int       checks   = 0;
    int       failures = 0;

    wbu_writeback #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rd        (in_rd),
        .in_rd_wen    (in_rd_wen),
        .in_is_load   (in_is_load),
        .in_load_fmt  (in_load_fmt),
        .in_addr_lo   (in_addr_lo),
        .in_result    (in_result),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .rf_we        (rf_we),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .pend_valid   (pend_valid),
        .pend_rd      (pend_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rf_we"},        32'(rf_we), 32'd0);
        checkOutput({tag, "_rf_rd_addr"},   32'(rf_rd_addr), 32'd0);
        checkOutput({tag, "_rf_rd_data"},   rf_rd_data, 32'd0);
        checkOutput({tag, "_commit_valid"}, 32'(commit_valid), 32'd0);
        checkOutput({tag, "_commit_pc"},    commit_pc, 32'd0);
        checkOutput({tag, "_pend_valid"},   32'(pend_valid), 32'd0);
        checkOutput({tag, "_pend_rd"},      32'(pend_rd), 32'd0);
        checkOutput({tag, "_in_ready"},     32'(in_ready), 32'd1);
    endtask

    // Scrambles the instruction inputs so the DUT cannot rely on them after acceptance.
    task automatic scrambleInputs();
        in_pc       = $urandom;
        in_rd       = 5'($urandom);
        in_rd_wen   = 1'($urandom);
        in_is_load  = 1'($urandom);
        in_load_fmt = 3'($urandom);
        in_addr_lo  = 2'($urandom);
        in_result   = $urandom;
    endtask

    task automatic applyStimulus(input vec_t v, input logic [31:0] pc, input int waitCycles);
        sbEntry_t e;
        @(negedge clk);
        checkOutput("ready_idle", 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_rd       = v.rd;
        in_rd_wen   = v.wen;
        in_is_load  = v.isLoad;
        in_load_fmt = v.fmt;
        in_addr_lo  = v.addrLo;
        in_result   = v.result;
        @(posedge clk);
        e.pc   = pc;
        e.rd   = v.rd;
        e.we   = v.expWe;
        e.data = v.expData;
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
        scrambleInputs();
        if (v.isLoad) begin
            for (int c = 0; c < waitCycles; c++) begin
                @(negedge clk);
                checkOutput("wait_ready", 32'(in_ready), 32'd0);
                checkOutput("wait_pend", 32'(pend_valid), 32'(v.expWe));
                if (v.expWe) checkOutput("wait_pend_rd", 32'(pend_rd), 32'(v.rd));
                checkOutput("wait_rf_we", 32'(rf_we), 32'd0);
                checkOutput("wait_commit", 32'(commit_valid), 32'd0);
            end
            @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata  = v.mdata;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        @(negedge clk);
        checkOutput("commit_latency", 32'(commit_valid), 32'd1);
        checkOutput("write_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("ready_after", 32'(in_ready), 32'd1);
        checkOutput("idle_commit", 32'(commit_valid), 32'd0);
        checkOutput("idle_pend", 32'(pend_valid), 32'd0);
        if (sb.size() != 0) begin
            checkOutput("missing_commit", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Commit monitor: every commit pulse must match the oldest outstanding instruction.
    always @(negedge clk) begin
        if (!rst) begin
            if (commit_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_commit", 32'(commit_valid), 32'd0);
                end else begin
                    monEntry = sb.pop_front();
                    checkOutput("commit_pc", commit_pc, monEntry.pc);
                    checkOutput("rf_we", 32'(rf_we), 32'(monEntry.we));
                    checkOutput("pend_in_write", 32'(pend_valid), 32'(monEntry.we));
                    if (monEntry.we) begin
                        checkOutput("rf_rd_addr", 32'(rf_rd_addr), 32'(monEntry.rd));
                        checkOutput("rf_rd_data", rf_rd_data, monEntry.data);
                        checkOutput("pend_rd_write", 32'(pend_rd), 32'(monEntry.rd));
                    end
                end
            end else begin
                checkOutput("stray_rf_we", 32'(rf_we), 32'd0);
                checkOutput("stray_commit_pc", commit_pc, 32'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        scrambleInputs();
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        //          isLoad rd     wen   fmt     lo    result        mdata         we    expData
        vecs[0]  = '{1'b0, 5'd5,  1'b1, 3'b000, 2'd0, 32'h12345678, 32'h00000000, 1'b1, 32'h12345678};
        vecs[1]  = '{1'b0, 5'd0,  1'b1, 3'b000, 2'd0, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'h00000000};
        vecs[2]  = '{1'b0, 5'd3,  1'b0, 3'b000, 2'd0, 32'hCAFEF00D, 32'h00000000, 1'b0, 32'h00000000};
        vecs[3]  = '{1'b1, 5'd10, 1'b1, F3_LB,  2'd2, 32'hA5A5A5A5, 32'h80FF7F01, 1'b1, 32'hFFFFFFFF};
        vecs[4]  = '{1'b1, 5'd11, 1'b1, F3_LBU, 2'd3, 32'hA5A5A5A5, 32'h80FF7F01, 1'b1, 32'h00000080};
        vecs[5]  = '{1'b1, 5'd12, 1'b1, F3_LH,  2'd2, 32'hA5A5A5A5, 32'h80FF7F01, 1'b1, 32'hFFFF80FF};
        vecs[6]  = '{1'b1, 5'd13, 1'b1, F3_LHU, 2'd0, 32'hA5A5A5A5, 32'h80FF7F01, 1'b1, 32'h00007F01};
        vecs[7]  = '{1'b1, 5'd14, 1'b1, F3_LW,  2'd1, 32'hA5A5A5A5, 32'h80FF7F01, 1'b1, 32'h80FF7F01};
        vecs[8]  = '{1'b1, 5'd15, 1'b1, F3_LB,  2'd0, 32'hA5A5A5A5, 32'h80FF7F01, 1'b1, 32'h00000001};
        vecs[9]  = '{1'b1, 5'd16, 1'b1, F3_LH,  2'd3, 32'hA5A5A5A5, 32'h80FF7F01, 1'b1, 32'hFFFF80FF};
        vecs[10] = '{1'b1, 5'd17, 1'b1, F3_LHU, 2'd1, 32'hA5A5A5A5, 32'h80FF7F01, 1'b1, 32'h00007F01};
        vecs[11] = '{1'b1, 5'd18, 1'b1, 3'b111, 2'd2, 32'hA5A5A5A5, 32'h80FF7F01, 1'b1, 32'h80FF7F01};
        vecs[12] = '{1'b1, 5'd19, 1'b1, F3_LBU, 2'd1, 32'hA5A5A5A5, 32'h12345678, 1'b1, 32'h00000056};
        vecs[13] = '{1'b1, 5'd0,  1'b1, F3_LB,  2'd3, 32'hA5A5A5A5, 32'h7F000000, 1'b0, 32'h00000000};

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], 32'h80000000 + 32'(i * 4), int'($urandom_range(0, 3)));
        end

        // Long memory wait on a load with a real destination.
        applyStimulus('{1'b1, 5'd21, 1'b1, F3_LW, 2'd0, 32'h0, 32'h0BADF00D, 1'b1, 32'h0BADF00D},
                      32'h80001000, 5);

        // A memory response while idle must not produce a write or commit.
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11112222;
        repeat (2) begin
            @(negedge clk);
            checkOutput("idle_rvalid_we", 32'(rf_we), 32'd0);
            checkOutput("idle_rvalid_commit", 32'(commit_valid), 32'd0);
            checkOutput("idle_rvalid_ready", 32'(in_ready), 32'd1);
        end
        mem_rvalid = 1'b0;

        // Back-to-back non-loads with in_valid held high: accept every other cycle.
        @(negedge clk);
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_rd_wen  = 1'b1;
        in_pc      = 32'h90000000;
        in_rd      = 5'd7;
        in_result  = 32'h00000700;
        for (int i = 0; i < 3; i++) begin
            sbEntry_t e;
            checkOutput("b2b_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            e.pc   = in_pc;
            e.rd   = in_rd;
            e.we   = 1'b1;
            e.data = in_result;
            sb.push_back(e);
            #1;
            if (i < 2) begin
                in_pc     = 32'h90000000 + 32'((i + 1) * 4);
                in_rd     = 5'(8 + i);
                in_result = 32'h00000800 + 32'((i + 1) * 256);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            checkOutput("b2b_commit", 32'(commit_valid), 32'd1);
            checkOutput("b2b_busy", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        checkOutput("b2b_drained", 32'(sb.size()), 32'd0);
        sb.delete();

        // Reset while a load is waiting for memory drops the instruction.
        in_valid    = 1'b1;
        in_is_load  = 1'b1;
        in_rd_wen   = 1'b1;
        in_rd       = 5'd25;
        in_pc       = 32'h80002000;
        in_load_fmt = F3_LW;
        in_addr_lo  = 2'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_pend", 32'(pend_valid), 32'd1);
        checkOutput("pre_reset_ready", 32'(in_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h33334444;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (3) begin
            checkOutput("post_reset_we", 32'(rf_we), 32'd0);
            checkOutput("post_reset_commit", 32'(commit_valid), 32'd0);
            checkOutput("post_reset_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
